// File: rtl/tanh_layer_ctrl_pkg.sv
// Shared constants for the tanh layer scheduler: layer state codes,
// channel FSM encoding and the slot-index to state-code mapping.
package tanh_layer_ctrl_pkg;

   localparam int STATE_LEN = 5;

   localparam logic [STATE_LEN-1:0] F_TANH1 = 5'd5;
   localparam logic [STATE_LEN-1:0] F_TANH2 = 5'd6;
   localparam logic [STATE_LEN-1:0] F_TANH3 = 5'd7;
   localparam logic [STATE_LEN-1:0] B_TANH1 = 5'd13;
   localparam logic [STATE_LEN-1:0] B_TANH2 = 5'd14;
   localparam logic [STATE_LEN-1:0] B_TANH3 = 5'd15;

   typedef enum logic [1:0] {
      CH_IDLE = 2'd0,
      CH_RUN  = 2'd1,
      CH_WAIT = 2'd2,
      CH_DONE = 2'd3
   } ch_state_t;

   // Slot 1..3 to F_/B_TANHn; slot 0 is illegal and maps to 0.
   function automatic logic [STATE_LEN-1:0] tanh_code(input logic bwd, input logic [1:0] idx);
      logic [STATE_LEN-1:0] c;
      c = '0;
      case (idx)
         2'd1: c = bwd ? B_TANH1 : F_TANH1;
         2'd2: c = bwd ? B_TANH2 : F_TANH2;
         2'd3: c = bwd ? B_TANH3 : F_TANH3;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/tanh_layer_ctrl_ch_fsm.sv
// One tanh job channel: IDLE -> RUN -> WAIT -> DONE -> IDLE.
// Accept is combinational (ack in the request cycle); run/done are
// registered one-cycle pulses. err_o is a one-cycle set request for the
// top's sticky error (illegal slot or wait timeout).
// Optional TANH_CTRL_PERF_EN adds lat_o, the WAIT count of the last done job.
module tanh_ch_fsm
   import tanh_layer_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1023,
   parameter int CNT_W       = 10,
   parameter bit IS_BWD      = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_i,
   input  logic [1:0]           idx_i,
   input  logic                 allow_i,
   input  logic                 valid_i,
   output logic                 ack_o,
   output logic                 run_o,
   output logic                 done_o,
   output logic                 idle_o,
   output logic                 err_o,
   output logic [STATE_LEN-1:0] code_o
`ifdef TANH_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0]     lat_o
`endif
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

   ch_state_t             state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  run_q;
   logic                  done_q;
   logic [STATE_LEN-1:0]  code_q;
   logic                  accept;
   logic                  illegal;
   logic                  timeout;

   assign accept  = (state_q == CH_IDLE) & req_i & allow_i;
   assign illegal = accept & (idx_i == 2'd0);
   // Final WAIT cycle without valid: the timeout count is reached at this edge.
   assign timeout = (state_q == CH_WAIT) & ~valid_i & (cnt_q == LAST_CNT);

   assign ack_o  = accept;
   assign idle_o = (state_q == CH_IDLE);
   assign err_o  = illegal | timeout;
   assign run_o  = run_q;
   assign done_o = done_q;
   assign code_o = code_q;

   // Channel FSM with registered run/done pulses and the held state code.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CH_IDLE;
         cnt_q   <= '0;
         run_q   <= 1'b0;
         done_q  <= 1'b0;
         code_q  <= '0;
      end else begin
         run_q  <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            CH_IDLE: begin
               if (accept && !illegal) begin
                  state_q <= CH_RUN;
                  run_q   <= 1'b1;
                  code_q  <= tanh_code(IS_BWD, idx_i);
               end
            end
            CH_RUN: begin
               state_q <= CH_WAIT;
               cnt_q   <= '0;
            end
            CH_WAIT: begin
               if (valid_i) begin
                  state_q <= CH_DONE;
                  done_q  <= 1'b1;
               end else if (timeout) begin
                  state_q <= CH_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            CH_DONE: state_q <= CH_IDLE;
            default: state_q <= CH_IDLE;
         endcase
      end
   end

`ifdef TANH_CTRL_PERF_EN
   logic [CNT_W-1:0] lat_q;
   // Capture the wait length of each completed job.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  lat_q <= '0;
      else if (state_q == CH_DONE) lat_q <= cnt_q;
   end
   assign lat_o = lat_q;
`endif

endmodule

// File: rtl/tanh_layer_ctrl.sv
// Three-slot tanh layer scheduler: forward and backward channels run
// concurrently; backward jobs need a fresh forward snapshot, taken with a
// load_backward pulse only while both channels are idle.
// Optional TANH_CTRL_PERF_EN adds fwd_lat, bwd_lat and load_cnt outputs.
module tanh_layer_ctrl
   import tanh_layer_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1023,
   parameter int CNT_W       = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 fwd_req,
   input  logic [1:0]           fwd_idx,
   output logic                 fwd_ack,
   input  logic                 bwd_req,
   input  logic [1:0]           bwd_idx,
   output logic                 bwd_ack,
   input  logic                 valid_forward,
   input  logic                 valid_backward,
   output logic                 run_forward,
   output logic                 run_backward,
   output logic                 load_backward,
   output logic [STATE_LEN-1:0] state_forward,
   output logic [STATE_LEN-1:0] state_backward,
   output logic                 fwd_done,
   output logic                 bwd_done,
   output logic                 busy,
   output logic                 err,
   input  logic                 err_clr
`ifdef TANH_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0]     fwd_lat,
   output logic [CNT_W-1:0]     bwd_lat,
   output logic [15:0]          load_cnt
`endif
);

   logic snap_q;
   logic err_q;
   logic fwd_idle, bwd_idle;
   logic fwd_err, bwd_err;
   logic load;

   // Snapshot is taken only with both channels quiet, and it blocks a forward accept.
   assign load = bwd_req & ~snap_q & fwd_idle & bwd_idle;

   tanh_ch_fsm #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W), .IS_BWD(1'b0)) u_fwd (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_i   (fwd_req),
      .idx_i   (fwd_idx),
      .allow_i (~load),
      .valid_i (valid_forward),
      .ack_o   (fwd_ack),
      .run_o   (run_forward),
      .done_o  (fwd_done),
      .idle_o  (fwd_idle),
      .err_o   (fwd_err),
      .code_o  (state_forward)
`ifdef TANH_CTRL_PERF_EN
      ,
      .lat_o   (fwd_lat)
`endif
   );

   tanh_ch_fsm #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W), .IS_BWD(1'b1)) u_bwd (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_i   (bwd_req),
      .idx_i   (bwd_idx),
      .allow_i (snap_q),
      .valid_i (valid_backward),
      .ack_o   (bwd_ack),
      .run_o   (run_backward),
      .done_o  (bwd_done),
      .idle_o  (bwd_idle),
      .err_o   (bwd_err),
      .code_o  (state_backward)
`ifdef TANH_CTRL_PERF_EN
      ,
      .lat_o   (bwd_lat)
`endif
   );

   assign load_backward = load;
   assign busy          = ~(fwd_idle & bwd_idle) | load;
   assign err           = err_q;

   // Snapshot freshness: a finished forward job stales it, a load refreshes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        snap_q <= 1'b0;
      else if (fwd_done) snap_q <= 1'b0;
      else if (load)     snap_q <= 1'b1;
   end

   // Sticky error; a new error wins over a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                err_q <= 1'b0;
      else if (fwd_err | bwd_err) err_q <= 1'b1;
      else if (err_clr)          err_q <= 1'b0;
   end

`ifdef TANH_CTRL_PERF_EN
   logic [15:0] load_cnt_q;
   // Free-running count of snapshot loads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    load_cnt_q <= '0;
      else if (load) load_cnt_q <= load_cnt_q + 16'd1;
   end
   assign load_cnt = load_cnt_q;
`endif

endmodule

// File: tb/tb_tanh_layer_ctrl.sv
// Bench for tanh_layer_ctrl: directed scenarios then random traffic, all
// outputs compared each cycle against a job-timeline reference model.
module tb_tanh_layer_ctrl;
   import tanh_layer_ctrl_pkg::*;

   localparam int TO = 1023;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic fwd_req = 1'b0, bwd_req = 1'b0;
   logic [1:0] fwd_idx = 2'd0, bwd_idx = 2'd0;
   logic valid_forward = 1'b0, valid_backward = 1'b0, err_clr = 1'b0;
   logic fwd_ack, bwd_ack, run_forward, run_backward, load_backward;
   logic fwd_done, bwd_done, busy, err;
   logic [STATE_LEN-1:0] state_forward, state_backward;
`ifdef TANH_CTRL_PERF_EN
   logic [9:0]  fwd_lat, bwd_lat;
   logic [15:0] load_cnt;
`endif

   tanh_layer_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(10)) dut (
      .clk(clk), .rst_n(rst_n),
      .fwd_req(fwd_req), .fwd_idx(fwd_idx), .fwd_ack(fwd_ack),
      .bwd_req(bwd_req), .bwd_idx(bwd_idx), .bwd_ack(bwd_ack),
      .valid_forward(valid_forward), .valid_backward(valid_backward),
      .run_forward(run_forward), .run_backward(run_backward),
      .load_backward(load_backward),
      .state_forward(state_forward), .state_backward(state_backward),
      .fwd_done(fwd_done), .bwd_done(bwd_done),
      .busy(busy), .err(err), .err_clr(err_clr)
`ifdef TANH_CTRL_PERF_EN
      , .fwd_lat(fwd_lat), .bwd_lat(bwd_lat), .load_cnt(load_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: per channel, age of the job since accept (-1 = no job),
   // cycles waited so far, pending done pulse, and the reported slot code.
   int                   age [2];
   int                   waited [2];
   bit                   dpend [2];
   logic [STATE_LEN-1:0] mcode [2];
   bit                   msnap, merr;
   logic [STATE_LEN-1:0] code_tab [2][4];

   // One clock: called at a negedge with inputs set; compares, advances model.
   task automatic step();
      bit ack [2], run [2], done [2], idle [2], tmo [2], vld [2], req [2];
      logic [1:0] idx [2];
      bit load, busy_m, errset;
      logic [31:0] expv, gotv;
      #1;
      req[0] = fwd_req;  req[1] = bwd_req;
      idx[0] = fwd_idx;  idx[1] = bwd_idx;
      vld[0] = valid_forward; vld[1] = valid_backward;
      if (!rst_n) begin
         for (int c = 0; c < 2; c++) begin
            age[c] = -1; waited[c] = 0; dpend[c] = 0; mcode[c] = '0;
            ack[c] = 0;
         end
         msnap = 0; merr = 0;
         expv = '0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            idle[c] = (age[c] < 0);
            run[c]  = (age[c] == 1);
            done[c] = dpend[c];
            tmo[c]  = (age[c] >= 2) && !dpend[c] && !vld[c] && (waited[c] == TO - 1);
         end
         load   = req[1] && !msnap && idle[0] && idle[1];
         ack[0] = req[0] && idle[0] && !load;
         ack[1] = req[1] && idle[1] && msnap;
         busy_m = !idle[0] || !idle[1] || load;
         expv = {13'd0, ack[0], ack[1], run[0], run[1], load, done[0], done[1],
                 busy_m, merr, mcode[0], mcode[1]};
         errset = tmo[0] || tmo[1] || (ack[0] && idx[0] == 2'd0) || (ack[1] && idx[1] == 2'd0);
         if (errset) merr = 1; else if (err_clr) merr = 0;
         if (done[0]) msnap = 0; else if (load) msnap = 1;
         for (int c = 0; c < 2; c++) begin
            if (dpend[c]) begin
               dpend[c] = 0; age[c] = -1;
            end else if (age[c] >= 1) begin
               if (age[c] >= 2 && vld[c]) dpend[c] = 1;
               else if (tmo[c]) age[c] = -1;
               else begin
                  if (age[c] >= 2) waited[c]++;
                  else waited[c] = 0;
                  age[c]++;
               end
            end else if (ack[c] && idx[c] != 2'd0) begin
               age[c] = 1;
               mcode[c] = code_tab[c][idx[c]];
            end
         end
      end
      gotv = {13'd0, fwd_ack, bwd_ack, run_forward, run_backward, load_backward,
              fwd_done, bwd_done, busy, err, state_forward, state_backward};
      chk("outs", gotv, expv);
      @(posedge clk);
      @(negedge clk);
      if (ack[0]) fwd_req = 1'b0;
      if (ack[1]) bwd_req = 1'b0;
   endtask

   initial begin
      code_tab[0][0] = '0;  code_tab[0][1] = F_TANH1; code_tab[0][2] = F_TANH2; code_tab[0][3] = F_TANH3;
      code_tab[1][0] = '0;  code_tab[1][1] = B_TANH1; code_tab[1][2] = B_TANH2; code_tab[1][3] = B_TANH3;
      @(negedge clk);
      repeat (2) step();
      chk("rst_state", {26'd0, busy, err, load_backward, run_forward, fwd_ack, bwd_ack}, 32'd0);
      rst_n = 1'b1;
      step();

      // forward slot 2, valid five cycles after run
      fwd_req = 1'b1; fwd_idx = 2'd2;
      step();
      repeat (5) step();
      valid_forward = 1'b1; step(); valid_forward = 1'b0;
      repeat (2) step();
      chk("f2_state", 32'(state_forward), 32'(F_TANH2));

      // backward slot 3 needs a load first
      bwd_req = 1'b1; bwd_idx = 2'd3;
      repeat (5) step();
      valid_backward = 1'b1; step(); valid_backward = 1'b0;
      repeat (2) step();
      chk("b3_state", 32'(state_backward), 32'(B_TANH3));

      // stale the snapshot with a forward job, then request both together
      fwd_req = 1'b1; fwd_idx = 2'd1;
      repeat (2) step();
      valid_forward = 1'b1; step(); valid_forward = 1'b0;
      repeat (2) step();
      fwd_req = 1'b1; fwd_idx = 2'd3; bwd_req = 1'b1; bwd_idx = 2'd1;
      repeat (4) step();
      valid_forward = 1'b1; valid_backward = 1'b1; step();
      valid_forward = 1'b0; valid_backward = 1'b0;
      repeat (2) step();

      // timeout on forward
      fwd_req = 1'b1; fwd_idx = 2'd1;
      repeat (TO + 6) step();
      chk("tmo_err", 32'(err), 32'd1);
      chk("tmo_nodone", 32'({busy, fwd_done}), 32'd0);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      step();
      chk("clr_err", 32'(err), 32'd0);
      fwd_req = 1'b1; fwd_idx = 2'd2;
      repeat (3) step();
      valid_forward = 1'b1; step(); valid_forward = 1'b0;
      repeat (2) step();

      // illegal slot; then illegal together with err_clr keeps err set
      fwd_req = 1'b1; fwd_idx = 2'd0;
      repeat (2) step();
      chk("ill_err", 32'(err), 32'd1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      fwd_req = 1'b1; fwd_idx = 2'd0; err_clr = 1'b1;
      step(); err_clr = 1'b0;
      step();
      chk("ill_clr_err", 32'(err), 32'd1);
      err_clr = 1'b1; step(); err_clr = 1'b0;

      // reset while waiting, late valid must be ignored
      fwd_req = 1'b1; fwd_idx = 2'd3;
      repeat (4) step();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      valid_forward = 1'b1; step(); valid_forward = 1'b0;
      step();
      chk("rst_mid_done", 32'({fwd_done, busy, run_forward}), 32'd0);

      // random traffic
      repeat (3000) begin
         if (!fwd_req && $urandom_range(3) == 0) begin
            fwd_req = 1'b1;
            fwd_idx = ($urandom_range(15) == 0) ? 2'd0 : 2'($urandom_range(3, 1));
         end
         if (!bwd_req && $urandom_range(3) == 0) begin
            bwd_req = 1'b1;
            bwd_idx = ($urandom_range(15) == 0) ? 2'd0 : 2'($urandom_range(3, 1));
         end
         valid_forward  = ($urandom_range(4) == 0);
         valid_backward = ($urandom_range(4) == 0);
         err_clr        = ($urandom_range(15) == 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
